// File: rtl/fish_pkg.sv
// Shared definitions for the fishing-line overlay: FSM encoding, colour key and
// the hook/bait sprite images (row-major, IMG_W pixels per row).
package fish_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FOLLOW = 2'd1,
        ST_REEL   = 2'd2
    } state_e;

    localparam logic [11:0] KEY_COLOR = 12'h352;

    localparam int IMG_W = 8;
    localparam int IMG_H = 19;
    localparam int IMG_N = IMG_W * IMG_H;

    // Palette shorthands so the images below read as pixel art.
    localparam logic [11:0] PK = KEY_COLOR;
    localparam logic [11:0] PS = 12'hBBB;
    localparam logic [11:0] PD = 12'h777;
    localparam logic [11:0] PW = 12'h865;
    localparam logic [11:0] PP = 12'hD87;

    // Hook occupies the top-left 7x15 of the frame; everything else is keyed out.
    localparam logic [0:IMG_N-1][11:0] HOOK_IMG = {
        PK, PK, PK, PK, PS, PS, PS, PK,
        PK, PK, PK, PK, PS, PK, PS, PK,
        PK, PK, PK, PK, PS, PS, PS, PK,
        PK, PK, PK, PK, PK, PS, PK, PK,
        PK, PK, PK, PK, PK, PS, PK, PK,
        PK, PK, PK, PK, PK, PS, PK, PK,
        PK, PK, PK, PK, PK, PS, PK, PK,
        PK, PK, PK, PK, PK, PS, PK, PK,
        PK, PK, PK, PK, PK, PS, PK, PK,
        PK, PK, PK, PK, PK, PS, PK, PK,
        PS, PK, PK, PK, PK, PS, PK, PK,
        PS, PK, PK, PK, PK, PS, PK, PK,
        PS, PS, PK, PK, PK, PS, PK, PK,
        PK, PS, PD, PK, PD, PS, PK, PK,
        PK, PK, PD, PD, PD, PK, PK, PK,
        PK, PK, PK, PK, PK, PK, PK, PK,
        PK, PK, PK, PK, PK, PK, PK, PK,
        PK, PK, PK, PK, PK, PK, PK, PK,
        PK, PK, PK, PK, PK, PK, PK, PK
    };

    localparam logic [0:IMG_N-1][11:0] BAIT_IMG = {
        PK, PW, PW, PK, PK, PK, PK, PK,
        PW, PP, PP, PW, PK, PK, PK, PK,
        PK, PW, PP, PP, PW, PK, PK, PK,
        PK, PK, PW, PP, PP, PW, PK, PK,
        PK, PK, PK, PW, PP, PP, PW, PK,
        PK, PK, PK, PW, PP, PP, PW, PK,
        PK, PK, PW, PP, PP, PW, PK, PK,
        PK, PW, PP, PP, PW, PK, PK, PK,
        PW, PP, PP, PW, PK, PK, PK, PK,
        PW, PP, PP, PW, PK, PK, PK, PK,
        PK, PW, PP, PP, PW, PK, PK, PK,
        PK, PK, PW, PP, PP, PW, PK, PK,
        PK, PK, PK, PW, PP, PP, PW, PK,
        PK, PK, PK, PW, PP, PP, PW, PK,
        PK, PK, PW, PP, PP, PW, PK, PK,
        PK, PW, PP, PP, PW, PK, PK, PK,
        PK, PW, PP, PW, PK, PK, PK, PK,
        PK, PK, PW, PK, PK, PK, PK, PK,
        PK, PK, PK, PK, PK, PK, PK, PK
    };

    function automatic logic [9:0] min10(input logic [9:0] a, input logic [9:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/hook_sprite_engine_if.sv
// Control and pixel-stream signals between game logic, the hook engine and the pixel mux.
interface hook_sprite_engine_if;
    logic        frame_tick;
    logic        cast;
    logic        reel;
    logic [1:0]  mode;
    logic [9:0]  target_v;
    logic [9:0]  h_cnt;
    logic [9:0]  v_cnt;
    logic        background;
    logic [11:0] vga;
    logic [9:0]  hook_v;
    logic [1:0]  state;
    logic        reel_done;

    modport master (
        output frame_tick, cast, reel, mode, target_v, h_cnt, v_cnt,
        input  background, vga, hook_v, state, reel_done
    );

    modport slave (
        input  frame_tick, cast, reel, mode, target_v, h_cnt, v_cnt,
        output background, vga, hook_v, state, reel_done
    );
endinterface

// File: rtl/hook_sprite_rom.sv
// Per-mode sprite ROM with a registered read; this register is the render pipeline stage.
module hook_sprite_rom
    import fish_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        sel,
    input  logic [ADDR_W-1:0] addr,
    output logic [11:0]       pixel
);

    logic [11:0] pixel_next;

    always_comb begin
        pixel_next = KEY_COLOR;
        if (int'(addr) < IMG_N) begin
            case (sel)
                2'd1:       pixel_next = HOOK_IMG[addr];
                2'd2, 2'd3: pixel_next = BAIT_IMG[addr];
                default:    pixel_next = KEY_COLOR;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixel <= KEY_COLOR;
        end else begin
            pixel <= pixel_next;
        end
    end

endmodule

// File: rtl/hook_sprite_engine.sv
// Hook motion controller (follow / reel FSM) and sprite renderer for the fishing-line overlay.
module hook_sprite_engine
    import fish_pkg::*;
#(
    parameter int          H_POS    = 277,
    parameter int          TOP_V    = 62,
    parameter int          BOTTOM_V = 470,
    parameter int          SPR_W    = 8,
    parameter int          SPR_H    = 19,
    parameter int          STEP     = 4,
    parameter logic [11:0] KEY      = KEY_COLOR
) (
    input  logic                 clk,
    input  logic                 rst_n,
    hook_sprite_engine_if.slave  bus
);

    localparam int         ADDR_W  = $clog2(SPR_W * SPR_H);
    localparam logic [9:0] TOP_C   = 10'(TOP_V);
    localparam logic [9:0] TGT_MAX = 10'(BOTTOM_V - SPR_H + 1);
    localparam logic [9:0] H_LO    = 10'(H_POS);
    localparam logic [9:0] H_HI    = 10'(H_POS + SPR_W - 1);
    localparam logic [9:0] STEP_C  = 10'(STEP);
    localparam logic [10:0] V_SPAN = 11'(SPR_H - 1);

    state_e      state_reg;
    logic [9:0]  hook_v_reg;
    logic        reel_done_reg;
    logic        win_reg;

    logic [9:0]  tgt;
    logic [9:0]  step_follow;
    logic [9:0]  follow_next;
    logic [9:0]  reel_next;

    // Target clamp keeps the whole sprite between the surface and the bottom row.
    always_comb begin
        tgt = bus.target_v;
        if (bus.target_v < TOP_C) begin
            tgt = TOP_C;
        end else if (bus.target_v > TGT_MAX) begin
            tgt = TGT_MAX;
        end
        step_follow = (tgt >= hook_v_reg) ? min10(STEP_C, tgt - hook_v_reg)
                                          : min10(STEP_C, hook_v_reg - tgt);
        follow_next = (tgt >= hook_v_reg) ? hook_v_reg + step_follow
                                          : hook_v_reg - step_follow;
        reel_next   = hook_v_reg - min10(STEP_C, hook_v_reg - TOP_C);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            hook_v_reg    <= TOP_C;
            reel_done_reg <= 1'b0;
        end else begin
            reel_done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    hook_v_reg <= TOP_C;
                    if (bus.cast) begin
                        state_reg <= ST_FOLLOW;
                    end
                end
                ST_FOLLOW: begin
                    if (bus.frame_tick) begin
                        hook_v_reg <= follow_next;
                    end
                    // reel has priority over cast; cast is a no-op while following
                    if (bus.reel) begin
                        state_reg <= ST_REEL;
                    end
                end
                ST_REEL: begin
                    if (bus.frame_tick) begin
                        hook_v_reg <= reel_next;
                        if (reel_next == TOP_C) begin
                            state_reg     <= ST_IDLE;
                            reel_done_reg <= 1'b1;
                        end
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    logic              in_h;
    logic              in_v;
    logic              in_win;
    logic [9:0]        row_off;
    logic [9:0]        col_off;
    logic [ADDR_W-1:0] rom_addr;
    logic [11:0]       rom_pixel;
    logic              hit;

    // Offsets are only formed inside the window so the subtractions never wrap.
    always_comb begin
        in_h     = (bus.h_cnt >= H_LO) && (bus.h_cnt <= H_HI);
        in_v     = ({1'b0, bus.v_cnt} >= {1'b0, hook_v_reg}) &&
                   ({1'b0, bus.v_cnt} <= ({1'b0, hook_v_reg} + V_SPAN));
        in_win   = (bus.mode != 2'd0) && in_h && in_v;
        row_off  = in_win ? (bus.v_cnt - hook_v_reg) : 10'd0;
        col_off  = in_win ? (bus.h_cnt - H_LO) : 10'd0;
        rom_addr = ADDR_W'(row_off * SPR_W + col_off);
    end

    hook_sprite_rom #(
        .ADDR_W (ADDR_W)
    ) u_rom (
        .clk   (clk),
        .rst_n (rst_n),
        .sel   (bus.mode),
        .addr  (rom_addr),
        .pixel (rom_pixel)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_reg <= 1'b0;
        end else begin
            win_reg <= in_win;
        end
    end

    assign hit            = win_reg && (rom_pixel != KEY);
    assign bus.background = !hit;
    assign bus.vga        = hit ? rom_pixel : 12'h000;
    assign bus.hook_v     = hook_v_reg;
    assign bus.state      = state_reg;
    assign bus.reel_done  = reel_done_reg;

endmodule

// File: tb/tb_hook_sprite_engine.sv
// Scoreboard bench: the driver pushes model predictions, a negedge monitor pops and compares.
module tb_hook_sprite_engine;
    import fish_pkg::*;

    localparam int TOP     = 62;
    localparam int TGT_MAX = 452;
    localparam int HPOS    = 277;
    localparam int STP     = 4;
    localparam int KEYC    = 'h352;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    hook_sprite_engine_if bus();

    hook_sprite_engine #(
        .H_POS(277), .TOP_V(62), .BOTTOM_V(470), .SPR_W(8), .SPR_H(19), .STEP(4), .KEY(12'h352)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int cyc;
        int hv;
        int st;
        int done;
        int bg;
        int vga;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   m_pos   = TOP;
    int   m_phase = 0;   // 0 resting at surface, 1 following, 2 reeling in

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Colour the sprite shows at (h,v) for a hook whose top row is pos, or -1 if transparent.
    function automatic int exp_pixel(input int h, input int v, input int m, input int pos);
        logic [7:0]  a;
        logic [11:0] c;
        if (m == 0) return -1;
        if (h < HPOS || h > HPOS + 7) return -1;
        if (v < pos || v > pos + 18) return -1;
        a = 8'((v - pos) * 8 + (h - HPOS));
        c = (m == 1) ? HOOK_IMG[a] : BAIT_IMG[a];
        if (int'(c) == KEYC) return -1;
        return int'(c);
    endfunction

    task automatic drive(input bit ft, input bit c, input bit r, input int m,
                         input int tv, input int h, input int v);
        exp_t e;
        int   pix, t, np, nph, dn, d;
        bus.frame_tick = ft;
        bus.cast       = c;
        bus.reel       = r;
        bus.mode       = 2'(m);
        bus.target_v   = 10'(tv);
        bus.h_cnt      = 10'(h);
        bus.v_cnt      = 10'(v);
        pix = exp_pixel(h, v, m, m_pos);
        np = m_pos; nph = m_phase; dn = 0;
        if (m_phase == 0) begin
            if (c) nph = 1;
        end else if (m_phase == 1) begin
            if (ft) begin
                t = (tv < TOP) ? TOP : (tv > TGT_MAX) ? TGT_MAX : tv;
                d = (t > m_pos) ? t - m_pos : m_pos - t;
                if (d > STP) d = STP;
                np = (t > m_pos) ? m_pos + d : m_pos - d;
            end
            if (r) nph = 2;
        end else begin
            if (ft) begin
                d = m_pos - TOP;
                if (d > STP) d = STP;
                np = m_pos - d;
                if (np == TOP) begin
                    nph = 0;
                    dn  = 1;
                end
            end
        end
        e.cyc = cyc; e.hv = np; e.st = nph; e.done = dn;
        e.bg  = (pix < 0) ? 1 : 0;
        e.vga = (pix < 0) ? 0 : pix;
        q.push_back(e);
        if (ft || c || r)
            $display("[TB] cyc=%0d tick=%0b cast=%0b reel=%0b target=%0d -> hook_v=%0d state=%0d done=%0d",
                     cyc, ft, c, r, tv, np, nph, dn);
        m_pos = np;
        m_phase = nph;
        @(posedge clk);
        #1;
    endtask

    function automatic int near_h();
        return $urandom_range(290, 270);
    endfunction

    function automatic int near_v();
        return $urandom_range(m_pos + 22, m_pos - 3);
    endfunction

    task automatic quiet(input int n, input int m);
        for (int i = 0; i < n; i++)
            drive(0, 0, 0, m, $urandom_range(1023), near_h(), near_v());
    endtask

    task automatic ticks(input int n, input int tv, input bit c);
        for (int i = 0; i < n; i++) begin
            drive(1, c, 0, 1, tv, near_h(), near_v());
            drive(0, c, 0, 1, $urandom_range(1023), near_h(), near_v());
        end
    endtask

    // Monitor: every prediction issued before the last clock edge is due now.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0 && q[0].cyc < cyc) begin
                e = q.pop_front();
                chk("hook_v", bus.hook_v, e.hv);
                chk("state", bus.state, e.st);
                chk("reel_done", bus.reel_done, e.done);
                chk("background", bus.background, e.bg);
                chk("vga", bus.vga, e.vga);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bus.frame_tick = 0; bus.cast = 0; bus.reel = 0; bus.mode = 0;
        bus.target_v = 0; bus.h_cnt = 0; bus.v_cnt = 0;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_hook_v", bus.hook_v, TOP);
        chk("rst_state", bus.state, 0);
        chk("rst_reel_done", bus.reel_done, 0);
        chk("rst_background", bus.background, 1);
        chk("rst_vga", bus.vga, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Idle render around the sprite in hook mode, then mode 0.
        for (int v = 55; v <= 85; v++)
            for (int h = 270; h <= 290; h++)
                drive(0, 0, 0, 1, 0, h, v);
        quiet(60, 0);

        // Bounded follow to row 100.
        drive(0, 1, 0, 1, 0, near_h(), near_v());
        for (int i = 0; i < 12; i++) begin
            drive(1, 0, 0, 1, 100, near_h(), near_v());
            quiet(2, 1);
        end
        chk("follow_stop", bus.hook_v, 100);

        // Clamp at both ends of the travel.
        ticks(110, 600, 0);
        chk("clamp_bottom", bus.hook_v, TGT_MAX);
        ticks(110, 10, 0);
        chk("clamp_top", bus.hook_v, TOP);

        // Reel from row 70 with cast held; cast must not interfere.
        ticks(3, 70, 0);
        chk("reel_start", bus.hook_v, 70);
        drive(0, 0, 1, 1, 0, near_h(), near_v());
        chk("reel_state", bus.state, 2);
        drive(1, 1, 0, 1, 300, near_h(), near_v());
        drive(0, 1, 0, 1, 300, near_h(), near_v());
        drive(1, 1, 0, 1, 300, near_h(), near_v());
        chk("reel_done_pulse", bus.reel_done, 1);
        chk("reel_idle", bus.state, 0);
        drive(0, 0, 0, 1, 0, near_h(), near_v());
        chk("reel_done_clear", bus.reel_done, 0);

        // cast and reel together in FOLLOW, then reel from the surface.
        drive(0, 1, 0, 1, 0, near_h(), near_v());
        drive(0, 1, 1, 1, 0, near_h(), near_v());
        chk("both_cmd_state", bus.state, 2);
        drive(1, 0, 0, 1, 200, near_h(), near_v());
        chk("surface_reel_done", bus.reel_done, 1);

        // Bait pixel latency and a mode-0 change on the same pixel.
        drive(0, 0, 0, 2, 0, 278, 62);
        chk("bait_vga", bus.vga, 'h865);
        chk("bait_background", bus.background, 0);
        drive(0, 0, 0, 0, 0, 278, 62);
        chk("mode0_background", bus.background, 1);

        // Reset in the middle of a reel.
        drive(0, 1, 0, 1, 0, near_h(), near_v());
        ticks(10, 200, 0);
        drive(0, 0, 1, 1, 0, near_h(), near_v());
        drive(1, 0, 0, 1, 0, near_h(), near_v());
        bus.frame_tick = 0; bus.cast = 0; bus.reel = 0;
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midreel_rst_hook_v", bus.hook_v, TOP);
        chk("midreel_rst_state", bus.state, 0);
        chk("midreel_rst_done", bus.reel_done, 0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("midreel_rst_no_pulse", bus.reel_done, 0);
        end
        rst_n = 1'b1;
        m_pos = TOP;
        m_phase = 0;
        @(posedge clk);
        #1;

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            bit ft, c, r;
            int h, v;
            ft = ($urandom_range(5) == 0);
            c  = ($urandom_range(19) == 0);
            r  = ($urandom_range(39) == 0);
            if ($urandom_range(4) == 0) begin
                h = $urandom_range(1023);
                v = $urandom_range(1023);
            end else begin
                h = near_h();
                v = near_v();
            end
            drive(ft, c, r, $urandom_range(3), $urandom_range(1023), h, v);
        end

        bus.frame_tick = 0; bus.cast = 0; bus.reel = 0;
        for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d predictions left unchecked, required 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
